// File: rtl/bilinear_interp_pipe.sv
// Three-stage bilinear blend of four neighbouring pixels with per-channel
// round/saturate; one global advance signal stalls the whole pipe.
module bilinear_interp_pipe #(
  parameter int               PIX_FMT  = 0,
  parameter int               PIX_W    = 16,
  parameter int               COEF_W   = 17,
  parameter int               FRAC_W   = 16,
  parameter int               ROUND    = 1,
  parameter logic [PIX_W-1:0] IDLE_VAL = 16'hFF00
) (
  input  logic              vin_clk,
  input  logic              rst,
  input  logic              frame_sync_n,
  input  logic              coo_valid,
  output logic              coo_ready,
  input  logic [COEF_W-1:0] coefficient1,
  input  logic [COEF_W-1:0] coefficient2,
  input  logic [COEF_W-1:0] coefficient3,
  input  logic [COEF_W-1:0] coefficient4,
  input  logic [PIX_W-1:0]  doutbx,
  input  logic [PIX_W-1:0]  doutbx1,
  input  logic [PIX_W-1:0]  doutby,
  input  logic [PIX_W-1:0]  doutby1,
  output logic [PIX_W-1:0]  vout_dat,
  output logic              vout_valid,
  input  logic              vout_ready,
  output logic [15:0]       pix_cnt
);

  localparam int WW    = 2 * COEF_W;
  localparam int CW_RB = (PIX_FMT == 0) ? 5 : 8;
  localparam int CW_G  = (PIX_FMT == 0) ? 6 : 8;

  logic             adv;
  logic             accept;
  logic             flush;

  logic [WW-1:0]    w_d [4];
  logic [WW-1:0]    w_q [4];
  logic [PIX_W-1:0] p_d [4];
  logic [PIX_W-1:0] p_q [4];
  logic             s1_vld_q;
  logic             s2_vld_q;
  logic             vout_valid_q;
  logic [PIX_W-1:0] vout_dat_q;
  logic [15:0]      pix_cnt_q;
  logic [PIX_W-1:0] res_d;

  assign adv       = ~vout_valid_q | vout_ready;
  assign flush     = ~frame_sync_n;
  assign coo_ready = adv & ~rst & frame_sync_n;
  assign accept    = coo_valid & coo_ready;

  always_comb begin
    w_d[0] = WW'(coefficient1) * WW'(coefficient3);
    w_d[1] = WW'(coefficient2) * WW'(coefficient3);
    w_d[2] = WW'(coefficient1) * WW'(coefficient4);
    w_d[3] = WW'(coefficient2) * WW'(coefficient4);
    p_d[0] = doutbx;
    p_d[1] = doutbx1;
    p_d[2] = doutby;
    p_d[3] = doutby1;
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge vin_clk) begin
    if (accept) begin
      w_q <= w_d;
      p_q <= p_d;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    // ch 0 = blue (LSBs), 1 = green, 2 = red (MSBs)
    localparam int CW  = (ch == 1) ? CW_G : CW_RB;
    localparam int LSB = (ch == 0) ? 0 : ((ch == 1) ? CW_RB : CW_RB + CW_G);
    localparam int TW  = WW + CW;
    localparam int SW  = TW + 3;
    localparam logic [SW-1:0] RND  = (ROUND != 0) ? (SW'(1) << (2 * FRAC_W - 1)) : '0;
    localparam logic [SW-1:0] MAXV = (SW'(1) << CW) - SW'(1);

    logic [TW-1:0] term_d [4];
    logic [TW-1:0] term_q [4];
    logic [SW-1:0] sum;
    logic [SW-1:0] shifted;
    logic [CW-1:0] sat;

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        term_d[k] = TW'(w_q[k]) * TW'(p_q[k][LSB +: CW]);
      end
    end

    always_ff @(posedge vin_clk) begin
      if (adv) begin
        term_q <= term_d;
      end
    end

    always_comb begin
      sum     = SW'(term_q[0]) + SW'(term_q[1]) + SW'(term_q[2]) + SW'(term_q[3]) + RND;
      shifted = sum >> (2 * FRAC_W);
      sat     = (shifted > MAXV) ? {CW{1'b1}} : shifted[CW-1:0];
    end

    assign res_d[LSB +: CW] = sat;
  end

  always_ff @(posedge vin_clk) begin
    if (rst || flush) begin
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      vout_valid_q <= 1'b0;
      vout_dat_q   <= IDLE_VAL;
      pix_cnt_q    <= 16'd0;
    end else begin
      if (adv) begin
        s1_vld_q     <= accept;
        s2_vld_q     <= s1_vld_q;
        vout_valid_q <= s2_vld_q;
        vout_dat_q   <= s2_vld_q ? res_d : IDLE_VAL;
      end
      if (vout_valid_q && vout_ready && (pix_cnt_q != 16'hFFFF)) begin
        pix_cnt_q <= pix_cnt_q + 16'd1;
      end
    end
  end

  assign vout_dat   = vout_dat_q;
  assign vout_valid = vout_valid_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Bench for bilinear_interp_pipe: directed vector table, stall/flush/reset
// sequences and a randomized stream scored against an arithmetic model.
module tb_bilinear_interp_pipe;

  logic        vin_clk = 1'b0;
  logic        rst, frame_sync_n, coo_valid, vout_ready;
  logic        coo_ready, vout_valid, coo_ready_t, vout_valid_t;
  logic [16:0] coefficient1, coefficient2, coefficient3, coefficient4;
  logic [15:0] doutbx, doutbx1, doutby, doutby1;
  logic [15:0] vout_dat, vout_dat_t, pix_cnt, pix_cnt_t;

  always #5 vin_clk = ~vin_clk;

  bilinear_interp_pipe dut (
    .vin_clk(vin_clk), .rst(rst), .frame_sync_n(frame_sync_n),
    .coo_valid(coo_valid), .coo_ready(coo_ready),
    .coefficient1(coefficient1), .coefficient2(coefficient2),
    .coefficient3(coefficient3), .coefficient4(coefficient4),
    .doutbx(doutbx), .doutbx1(doutbx1), .doutby(doutby), .doutby1(doutby1),
    .vout_dat(vout_dat), .vout_valid(vout_valid), .vout_ready(vout_ready),
    .pix_cnt(pix_cnt)
  );

  bilinear_interp_pipe #(.ROUND(0)) dut_trunc (
    .vin_clk(vin_clk), .rst(rst), .frame_sync_n(frame_sync_n),
    .coo_valid(coo_valid), .coo_ready(coo_ready_t),
    .coefficient1(coefficient1), .coefficient2(coefficient2),
    .coefficient3(coefficient3), .coefficient4(coefficient4),
    .doutbx(doutbx), .doutbx1(doutbx1), .doutby(doutby), .doutby1(doutby1),
    .vout_dat(vout_dat_t), .vout_valid(vout_valid_t), .vout_ready(vout_ready),
    .pix_cnt(pix_cnt_t)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge vin_clk);
    #1;
  endtask

  // RGB565 reference: weighted sum of each channel, optional half-up, >>32, clamp.
  function automatic logic [15:0] ref_pix(input logic [16:0] c1, c2, c3, c4,
                                          input logic [15:0] p1, p2, p3, p4,
                                          input bit rnd);
    longint unsigned w [4];
    longint unsigned s, r, mask;
    logic [15:0]     p [4];
    int              lsb [3];
    int              cw [3];
    logic [15:0]     res;
    w[0] = 64'(c1) * 64'(c3);
    w[1] = 64'(c2) * 64'(c3);
    w[2] = 64'(c1) * 64'(c4);
    w[3] = 64'(c2) * 64'(c4);
    p[0] = p1; p[1] = p2; p[2] = p3; p[3] = p4;
    lsb[0] = 0; lsb[1] = 5; lsb[2] = 11;
    cw[0]  = 5; cw[1]  = 6; cw[2]  = 5;
    res = 16'h0000;
    for (int ch = 0; ch < 3; ch++) begin
      mask = (64'(1) << cw[ch]) - 64'(1);
      s = 0;
      for (int k = 0; k < 4; k++) begin
        s += w[k] * ((64'(p[k]) >> lsb[ch]) & mask);
      end
      if (rnd) s += 64'(1) << 31;
      r = s >> 32;
      if (r > mask) r = mask;
      res = res | 16'(r << lsb[ch]);
    end
    return res;
  endfunction

  // Scoreboard: expected outputs in acceptance order.
  logic [15:0] exp_q [$];
  bit          mon_en = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_dat;
  int          mdl_cnt = 0;
  logic [15:0] exp_v;

  always @(negedge vin_clk) begin
    if (mon_en) begin
      if (rst || !frame_sync_n) begin
        exp_q.delete();
        mdl_cnt    = 0;
        prev_stall = 0;
      end else begin
        chk("coo_ready_rule", {31'd0, coo_ready}, {31'd0, (!vout_valid || vout_ready)});
        if (prev_stall) begin
          chk("stall_valid_held", {31'd0, vout_valid}, 32'd1);
          chk("stall_data_held", {16'd0, vout_dat}, {16'd0, prev_dat});
        end
        if (!vout_valid) chk("idle_value", {16'd0, vout_dat}, 32'h0000FF00);
        chk("pix_cnt_model", {16'd0, pix_cnt}, mdl_cnt);
        if (vout_valid && vout_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected no beat (t=%0t)", vout_dat, $time);
          end else begin
            exp_v = exp_q.pop_front();
            chk("stream_data", {16'd0, vout_dat}, {16'd0, exp_v});
          end
          if (mdl_cnt < 65535) mdl_cnt++;
          n_out++;
        end
        if (coo_valid && coo_ready)
          exp_q.push_back(ref_pix(coefficient1, coefficient2, coefficient3, coefficient4,
                                  doutbx, doutbx1, doutby, doutby1, 1'b1));
        prev_stall = vout_valid && !vout_ready;
        prev_dat   = vout_dat;
      end
    end
  end

  typedef struct {
    string       name;
    logic [16:0] c1, c2, c3, c4;
    logic [15:0] p1, p2, p3, p4;
    logic [15:0] exp_rnd;
    logic [15:0] exp_trunc;
  } vec_t;

  vec_t vecs [6];

  task automatic apply_vec(input vec_t v);
    int lat;
    coefficient1 = v.c1; coefficient2 = v.c2; coefficient3 = v.c3; coefficient4 = v.c4;
    doutbx = v.p1; doutbx1 = v.p2; doutby = v.p3; doutby1 = v.p4;
    coo_valid = 1'b1;
    vout_ready = 1'b1;
    #1;
    chk({v.name, "_ready"}, {31'd0, coo_ready}, 32'd1);
    tick();
    coo_valid = 1'b0;
    lat = 1;
    while (!vout_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk({v.name, "_latency"}, lat, 3);
    chk({v.name, "_round"}, {16'd0, vout_dat}, {16'd0, v.exp_rnd});
    chk({v.name, "_trunc"}, {16'd0, vout_dat_t}, {16'd0, v.exp_trunc});
    tick();
  endtask

  task automatic rand_inputs();
    coefficient1 = 17'($urandom_range(0, 131071));
    coefficient2 = 17'($urandom_range(0, 131071));
    coefficient3 = 17'($urandom_range(0, 131071));
    coefficient4 = 17'($urandom_range(0, 131071));
    doutbx  = 16'($urandom);
    doutbx1 = 16'($urandom);
    doutby  = 16'($urandom);
    doutby1 = 16'($urandom);
  endtask

  initial begin
    int  sent, base, c;
    bit  saw_block;

    vecs[0] = '{"unity_tl",   17'd65536, 17'd0,     17'd65536, 17'd0,
                16'hF81F, 16'h0000, 16'h0000, 16'h0000, 16'hF81F, 16'hF81F};
    vecs[1] = '{"half_br",    17'd32768, 17'd32768, 17'd32768, 17'd32768,
                16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h4208, 16'h39E7};
    vecs[2] = '{"sum4_0842",  17'd65536, 17'd65536, 17'd65536, 17'd65536,
                16'h0842, 16'h0842, 16'h0842, 16'h0842, 16'h2108, 16'h2108};
    vecs[3] = '{"sum4_sat",   17'd65536, 17'd65536, 17'd65536, 17'd65536,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{"half_top",   17'd32768, 17'd32768, 17'd65536, 17'd0,
                16'h0000, 16'h0841, 16'h0000, 16'h0000, 16'h0821, 16'h0020};
    vecs[5] = '{"zero_coef",  17'd0,     17'd0,     17'd0,     17'd0,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};

    rst = 1'b1; frame_sync_n = 1'b1; coo_valid = 1'b0; vout_ready = 1'b1;
    coefficient1 = '0; coefficient2 = '0; coefficient3 = '0; coefficient4 = '0;
    doutbx = '0; doutbx1 = '0; doutby = '0; doutby1 = '0;
    tick(); tick(); tick();
    chk("rst_valid", {31'd0, vout_valid}, 32'd0);
    chk("rst_dat", {16'd0, vout_dat}, 32'h0000FF00);
    chk("rst_pix_cnt", {16'd0, pix_cnt}, 32'd0);
    chk("rst_ready_low", {31'd0, coo_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, coo_ready}, 32'd1);
    mon_en = 1;

    foreach (vecs[i]) apply_vec(vecs[i]);
    chk("pix_cnt_after_vecs", {16'd0, pix_cnt}, 32'd6);

    // Stall window while streaming six beats.
    frame_sync_n = 1'b0; tick(); frame_sync_n = 1'b1;
    base = n_out; sent = 0; saw_block = 0; c = 0;
    while (c < 40 && (n_out - base) < 6) begin
      rand_inputs();
      coo_valid  = (sent < 6);
      vout_ready = !(c >= 4 && c <= 8);
      #1;
      if (coo_valid && coo_ready) sent++;
      if (!coo_ready) saw_block = 1;
      tick();
      c++;
    end
    coo_valid = 1'b0; vout_ready = 1'b1;
    chk("stall_outputs", n_out - base, 6);
    chk("stall_ready_fell", {31'd0, saw_block}, 32'd1);
    chk("stall_pix_cnt", {16'd0, pix_cnt}, 32'd6);

    // Flush with two beats in flight; a beat offered during flush is ignored.
    base = n_out;
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); coo_valid = 1'b1; tick();
    end
    rand_inputs();
    frame_sync_n = 1'b0;
    #1;
    chk("flush_ready_low", {31'd0, coo_ready}, 32'd0);
    tick();
    frame_sync_n = 1'b1; coo_valid = 1'b0;
    chk("flush_valid", {31'd0, vout_valid}, 32'd0);
    chk("flush_dat", {16'd0, vout_dat}, 32'h0000FF00);
    chk("flush_pix_cnt", {16'd0, pix_cnt}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("flush_no_ghosts", n_out - base, 0);

    // Reset mid-stream with the pipe full and stalled, flush asserted alongside.
    vout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs(); coo_valid = 1'b1; tick();
    end
    rst = 1'b1; frame_sync_n = 1'b0;
    #1;
    chk("rst_mid_ready_low", {31'd0, coo_ready}, 32'd0);
    tick();
    chk("rst_mid_valid", {31'd0, vout_valid}, 32'd0);
    chk("rst_mid_dat", {16'd0, vout_dat}, 32'h0000FF00);
    chk("rst_mid_pix_cnt", {16'd0, pix_cnt}, 32'd0);
    rst = 1'b0; frame_sync_n = 1'b1; coo_valid = 1'b0;
    #1;
    chk("rst_mid_ready_back", {31'd0, coo_ready}, 32'd1);
    base = n_out;
    apply_vec(vecs[0]);
    chk("rst_mid_single_out", n_out - base, 1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      coo_valid    = ($urandom_range(0, 3) != 0);
      vout_ready   = ($urandom_range(0, 2) != 0);
      frame_sync_n = ($urandom_range(0, 79) != 0);
      tick();
    end
    frame_sync_n = 1'b1; coo_valid = 1'b0; vout_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
